// File: rtl/cpu_sequencer_if.sv
// Control/handshake bundle between the instruction sequencer and the
// datapath and memories it drives.
interface cpu_sequencer_if;
    logic       run;
    logic [5:0] opcode;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       ir_ld;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_en;
    logic       werf_en;
    logic       illop;
    logic       bus_err;
    logic       busy;
    logic [2:0] state;

    modport master (
        input  run, opcode, imem_ack, dmem_ack,
        output imem_req, ir_ld, dmem_req, dmem_we, pc_en, werf_en, illop, bus_err, busy, state
    );

    modport slave (
        output run, opcode, imem_ack, dmem_ack,
        input  imem_req, ir_ld, dmem_req, dmem_we, pc_en, werf_en, illop, bus_err, busy, state
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback
// control with memory-wait timeout and illegal-opcode trap.
module cpu_sequencer #(
    parameter int unsigned MULDIV_CYCLES = 8,
    parameter int unsigned WAIT_TIMEOUT  = 255
) (
    input logic             clk,
    input logic             reset_n,
    cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StIll    = 3'd6
    } state_e;

    localparam logic [7:0] Timeout    = 8'(WAIT_TIMEOUT);
    localparam logic [7:0] MulDivLoad = 8'(MULDIV_CYCLES - 1);
    localparam logic [5:0] OpSt       = 6'h19;

    state_e     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [7:0] xcnt_q, xcnt_d;
    logic [5:0] op_q, op_d;
    logic       timed_out, timeout_d;
    logic       imem_req_q, dmem_req_q, dmem_we_q, pc_en_q, werf_en_q;
    logic       illop_q, bus_err_q, busy_q;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'h18, 6'h19, 6'h1b, [6'h1d:6'h1f], [6'h20:6'h26], [6'h28:6'h2a],
                          [6'h2c:6'h2e], [6'h30:6'h36], [6'h38:6'h3a], [6'h3c:6'h3e]};
    endfunction

    function automatic logic is_muldiv(input logic [5:0] op);
        return op inside {6'h22, 6'h23, 6'h32, 6'h33};
    endfunction

    function automatic logic is_memop(input logic [5:0] op);
        return op inside {6'h18, 6'h19, 6'h1f};
    endfunction

    // The cycle after the wait counter reaches the limit is the bus-error cycle;
    // an ACK in the last request cycle therefore always wins.
    assign timed_out = (wcnt_q == Timeout);
    assign timeout_d = (wcnt_d == Timeout);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        xcnt_d  = xcnt_q;
        op_d    = op_q;
        case (state_q)
            StIdle: begin
                if (bus.run) begin
                    state_d = StFetch;
                    wcnt_d  = 8'd0;
                end
            end
            StFetch: begin
                if (timed_out) begin
                    wcnt_d = 8'd0;
                end else if (bus.imem_ack) begin
                    state_d = StDecode;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            StDecode: begin
                op_d = bus.opcode;
                if (is_legal(bus.opcode)) begin
                    state_d = StExec;
                    xcnt_d  = is_muldiv(bus.opcode) ? MulDivLoad : 8'd0;
                end else begin
                    state_d = StIll;
                end
            end
            StExec: begin
                if (xcnt_q != 8'd0) begin
                    xcnt_d = xcnt_q - 8'd1;
                end else if (is_memop(op_q)) begin
                    state_d = StMem;
                    wcnt_d  = 8'd0;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (timed_out) begin
                    state_d = StFetch;
                    wcnt_d  = 8'd0;
                end else if (bus.dmem_ack) begin
                    state_d = StWb;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            StWb, StIll: begin
                state_d = bus.run ? StFetch : StIdle;
                wcnt_d  = 8'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered alongside the state they decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wcnt_q     <= 8'd0;
            xcnt_q     <= 8'd0;
            op_q       <= 6'd0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            pc_en_q    <= 1'b0;
            werf_en_q  <= 1'b0;
            illop_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            xcnt_q     <= xcnt_d;
            op_q       <= op_d;
            imem_req_q <= (state_d == StFetch) && !timeout_d;
            dmem_req_q <= (state_d == StMem) && !timeout_d;
            dmem_we_q  <= (state_d == StMem) && !timeout_d && (op_d == OpSt);
            pc_en_q    <= (state_d == StWb) || (state_d == StIll);
            werf_en_q  <= (state_d == StIll) || ((state_d == StWb) && (op_d != OpSt));
            illop_q    <= (state_d == StIll);
            bus_err_q  <= ((state_d == StFetch) || (state_d == StMem)) && timeout_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    assign bus.ir_ld    = (state_q == StFetch) && !timed_out && bus.imem_ack;
    assign bus.imem_req = imem_req_q;
    assign bus.dmem_req = dmem_req_q;
    assign bus.dmem_we  = dmem_we_q;
    assign bus.pc_en    = pc_en_q;
    assign bus.werf_en  = werf_en_q;
    assign bus.illop    = illop_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.busy     = busy_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a per-cycle script of stimulus and expected outputs is
// built from the instruction-level rules, then replayed against the DUT.
module tb_cpu_sequencer;
    localparam int MulDiv = 8;
    localparam int Tmo    = 4;

    localparam logic [2:0] SIdle = 3'd0, SFetch = 3'd1, SDec = 3'd2, SExec = 3'd3;
    localparam logic [2:0] SMem = 3'd4, SWb = 3'd5, SIll = 3'd6;

    // {imem_req, ir_ld, dmem_req, dmem_we, pc_en, werf_en, illop, bus_err, busy}
    localparam logic [8:0] IReq = 9'h100, IrLd = 9'h080, DReq = 9'h040, DWe = 9'h020;
    localparam logic [8:0] PcEn = 9'h010, Werf = 9'h008, Ill = 9'h004, BErr = 9'h002;
    localparam logic [8:0] Busy = 9'h001, None = 9'h000;

    localparam int LegalLo [10] = '{'h18, 'h19, 'h1b, 'h1d, 'h20, 'h28, 'h2c, 'h30, 'h38, 'h3c};
    localparam int LegalHi [10] = '{'h18, 'h19, 'h1b, 'h1f, 'h26, 'h2a, 'h2e, 'h36, 'h3a, 'h3e};
    localparam logic [5:0] Pool [10] = '{6'h18, 6'h19, 6'h1f, 6'h22, 6'h23, 6'h32, 6'h33,
                                         6'h20, 6'h00, 6'h27};

    typedef struct packed {
        logic       run;
        logic [5:0] op;
        logic       iack;
        logic       dack;
        logic [2:0] st;
        logic [8:0] outs;
    } cyc_t;

    logic  clk;
    logic  reset_n;
    cyc_t  script[$];
    string tag;
    int    step;
    int    total;
    int    bad;

    cpu_sequencer_if bus ();

    cpu_sequencer #(
        .MULDIV_CYCLES(MulDiv),
        .WAIT_TIMEOUT (Tmo)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] ro();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic legal(input logic [5:0] op);
        for (int i = 0; i < 10; i++)
            if (int'(op) >= LegalLo[i] && int'(op) <= LegalHi[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [8:0] outs_now();
        return {bus.imem_req, bus.ir_ld, bus.dmem_req, bus.dmem_we, bus.pc_en, bus.werf_en,
                bus.illop, bus.bus_err, bus.busy};
    endfunction

    task automatic push(input logic [2:0] st, input logic run, input logic [5:0] op,
                        input logic iack, input logic dack, input logic [8:0] outs);
        cyc_t c;
        c.run  = run;
        c.op   = op;
        c.iack = iack;
        c.dack = dack;
        c.st   = st;
        c.outs = outs | ((st != SIdle) ? Busy : None);
        script.push_back(c);
    endtask

    // Idle with RUN low for `hold` cycles, then one cycle with RUN high.
    task automatic gen_idle(input int hold);
        for (int i = 0; i < hold; i++) push(SIdle, 1'b0, ro(), rb(), rb(), None);
        push(SIdle, 1'b1, ro(), rb(), rb(), None);
    endtask

    // `ntmo` fetch timeouts, then ACK after `wait_c` unanswered request cycles.
    task automatic gen_fetch(input int ntmo, input int wait_c, input logic [5:0] op);
        for (int t = 0; t < ntmo; t++) begin
            for (int i = 0; i < Tmo; i++) push(SFetch, rb(), ro(), 1'b0, rb(), IReq);
            push(SFetch, rb(), ro(), 1'b0, rb(), BErr);
        end
        for (int i = 0; i < wait_c; i++) push(SFetch, rb(), ro(), 1'b0, rb(), IReq);
        push(SFetch, rb(), op, 1'b1, rb(), IReq | IrLd);
    endtask

    task automatic gen_body(input logic [5:0] op, input int mwait, input logic mtmo,
                            input logic run_next, output logic mem_tmo);
        logic [8:0] we;
        int         n;
        mem_tmo = 1'b0;
        push(SDec, rb(), op, rb(), rb(), None);
        if (!legal(op)) begin
            push(SIll, run_next, op, rb(), rb(), PcEn | Werf | Ill);
            return;
        end
        n = (op inside {6'h22, 6'h23, 6'h32, 6'h33}) ? MulDiv : 1;
        for (int i = 0; i < n; i++) push(SExec, rb(), op, rb(), rb(), None);
        if (op inside {6'h18, 6'h19, 6'h1f}) begin
            we = (op == 6'h19) ? DWe : None;
            if (mtmo) begin
                for (int i = 0; i < Tmo; i++) push(SMem, rb(), op, rb(), 1'b0, DReq | we);
                push(SMem, rb(), op, rb(), 1'b0, BErr);
                mem_tmo = 1'b1;
                return;
            end
            for (int i = 0; i < mwait; i++) push(SMem, rb(), op, rb(), 1'b0, DReq | we);
            push(SMem, rb(), op, rb(), 1'b1, DReq | we);
        end
        push(SWb, run_next, op, rb(), rb(), PcEn | ((op != 6'h19) ? Werf : None));
    endtask

    task automatic play();
        cyc_t c;
        while (script.size() > 0) begin
            c = script.pop_front();
            @(negedge clk);
            bus.run      = c.run;
            bus.opcode   = c.op;
            bus.imem_ack = c.iack;
            bus.dmem_ack = c.dack;
            #1;
            step++;
            total++;
            assert (bus.state === c.st) else begin
                bad++;
                $error("FAIL %s.state step=%0d got=%0d want=%0d", tag, step, bus.state, c.st);
            end
            total++;
            assert (outs_now() === c.outs) else begin
                bad++;
                $error("FAIL %s.outs step=%0d got=%b want=%b", tag, step, outs_now(), c.outs);
            end
        end
    endtask

    initial begin
        logic mt;
        total = 0;
        bad   = 0;
        step  = 0;
        reset_n      = 1'b0;
        bus.run      = 1'b0;
        bus.opcode   = 6'd0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;

        tag = "reset";
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        assert (bus.state === SIdle) else begin
            bad++;
            $error("FAIL reset.state got=%0d want=0", bus.state);
        end
        total++;
        assert (outs_now() === None) else begin
            bad++;
            $error("FAIL reset.outs got=%b want=%b", outs_now(), None);
        end
        reset_n = 1'b1;

        tag = "add";
        gen_idle(2);
        gen_fetch(0, 0, 6'h20);
        gen_body(6'h20, 0, 1'b0, 1'b1, mt);
        play();

        tag = "st";
        gen_fetch(0, 1, 6'h19);
        gen_body(6'h19, 2, 1'b0, 1'b1, mt);
        play();

        tag = "div";
        gen_fetch(0, 0, 6'h23);
        gen_body(6'h23, 0, 1'b0, 1'b1, mt);
        play();

        tag = "illegal";
        gen_fetch(0, 0, 6'h00);
        gen_body(6'h00, 0, 1'b0, 1'b1, mt);
        play();

        tag = "fetch_tmo";
        gen_fetch(1, 0, 6'h21);
        gen_body(6'h21, 0, 1'b0, 1'b1, mt);
        play();

        tag = "fetch_ack_wins";
        gen_fetch(0, Tmo - 1, 6'h1f);
        gen_body(6'h1f, Tmo - 1, 1'b0, 1'b1, mt);
        play();

        tag = "mem_tmo";
        gen_fetch(0, 0, 6'h18);
        gen_body(6'h18, 0, 1'b1, 1'b1, mt);
        gen_fetch(0, 0, 6'h20);
        gen_body(6'h20, 0, 1'b0, 1'b0, mt);
        gen_idle(3);
        play();

        tag = "random";
        for (int k = 0; k < 40; k++) begin
            logic [5:0] op;
            logic       rn;
            int         idx;
            idx = int'($urandom_range(0, 9));
            op  = ($urandom_range(0, 1) == 0) ? Pool[idx] : ro();
            rn  = ($urandom_range(0, 3) != 0);
            gen_fetch(($urandom_range(0, 5) == 0) ? 1 : 0, int'($urandom_range(0, Tmo - 1)), op);
            gen_body(op, int'($urandom_range(0, Tmo - 1)), ($urandom_range(0, 5) == 0), rn, mt);
            if (!mt && !rn) gen_idle(int'($urandom_range(0, 2)));
            play();
        end

        tag = "rst_mem";
        gen_fetch(0, 0, 6'h18);
        gen_body(6'h18, 0, 1'b0, 1'b1, mt);
        play();
        gen_fetch(0, 0, 6'h18);
        push(SDec, 1'b1, 6'h18, 1'b0, 1'b0, None);
        push(SExec, 1'b1, 6'h18, 1'b0, 1'b0, None);
        push(SMem, 1'b1, 6'h18, 1'b0, 1'b0, DReq);
        push(SMem, 1'b1, 6'h18, 1'b0, 1'b0, DReq);
        play();
        #1 reset_n = 1'b0;
        #1;
        total++;
        assert (bus.dmem_req === 1'b0) else begin
            bad++;
            $error("FAIL rst_mem.dmem_req got=%b want=0", bus.dmem_req);
        end
        total++;
        assert (bus.state === SIdle) else begin
            bad++;
            $error("FAIL rst_mem.state got=%0d want=0", bus.state);
        end
        total++;
        assert (outs_now() === None) else begin
            bad++;
            $error("FAIL rst_mem.outs got=%b want=%b", outs_now(), None);
        end
        bus.run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        tag = "after_rst";
        gen_idle(3);
        gen_fetch(0, 0, 6'h20);
        gen_body(6'h20, 0, 1'b0, 1'b0, mt);
        push(SIdle, 1'b0, 6'h00, 1'b0, 1'b0, None);
        play();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
